// File: rtl/lite_nasti_reader.sv
// Bridges single-word lite reads onto a wider NASTI read channel: one single-beat
// NASTI read per lite read, with the response word picked out of the wide beat.
module lite_nasti_reader #(
  parameter int MAX_TRANSACTION  = 2,
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  // lite read address
  input  logic [ID_WIDTH-1:0]         lite_ar_id,
  input  logic [ADDR_WIDTH-1:0]       lite_ar_addr,
  input  logic [2:0]                  lite_ar_prot,
  input  logic [3:0]                  lite_ar_qos,
  input  logic [3:0]                  lite_ar_region,
  input  logic [USER_WIDTH-1:0]       lite_ar_user,
  input  logic                        lite_ar_valid,
  output logic                        lite_ar_ready,
  // lite read response
  output logic [ID_WIDTH-1:0]         lite_r_id,
  output logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
  output logic [1:0]                  lite_r_resp,
  output logic [USER_WIDTH-1:0]       lite_r_user,
  output logic                        lite_r_valid,
  input  logic                        lite_r_ready,
  // NASTI read address
  output logic [ID_WIDTH-1:0]         nasti_ar_id,
  output logic [ADDR_WIDTH-1:0]       nasti_ar_addr,
  output logic [7:0]                  nasti_ar_len,
  output logic [2:0]                  nasti_ar_size,
  output logic [1:0]                  nasti_ar_burst,
  output logic                        nasti_ar_lock,
  output logic [3:0]                  nasti_ar_cache,
  output logic [2:0]                  nasti_ar_prot,
  output logic [3:0]                  nasti_ar_qos,
  output logic [3:0]                  nasti_ar_region,
  output logic [USER_WIDTH-1:0]       nasti_ar_user,
  output logic                        nasti_ar_valid,
  input  logic                        nasti_ar_ready,
  // NASTI read data
  input  logic [ID_WIDTH-1:0]         nasti_r_id,
  input  logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
  input  logic [1:0]                  nasti_r_resp,
  input  logic                        nasti_r_last,
  input  logic [USER_WIDTH-1:0]       nasti_r_user,
  input  logic                        nasti_r_valid,
  output logic                        nasti_r_ready
);

  localparam int RATIO     = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int WORD_LSB  = $clog2(LITE_DATA_WIDTH / 8);
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W     = (MAX_TRANSACTION > 1) ? $clog2(MAX_TRANSACTION) : 1;
  localparam int CNT_W     = $clog2(MAX_TRANSACTION + 1);

  // NASTI AR output register
  logic                   ar_valid_q,  ar_valid_d;
  logic [ID_WIDTH-1:0]    ar_id_q,     ar_id_d;
  logic [ADDR_WIDTH-1:0]  ar_addr_q,   ar_addr_d;
  logic [2:0]             ar_size_q,   ar_size_d;
  logic [1:0]             ar_burst_q,  ar_burst_d;
  logic [2:0]             ar_prot_q,   ar_prot_d;
  logic [3:0]             ar_qos_q,    ar_qos_d;
  logic [3:0]             ar_region_q, ar_region_d;
  logic [USER_WIDTH-1:0]  ar_user_q,   ar_user_d;

  // lite R output register
  logic                       r_valid_q, r_valid_d;
  logic [ID_WIDTH-1:0]        r_id_q,    r_id_d;
  logic [LITE_DATA_WIDTH-1:0] r_data_q,  r_data_d;
  logic [1:0]                 r_resp_q,  r_resp_d;
  logic [USER_WIDTH-1:0]      r_user_q,  r_user_d;

  // outstanding-read tracking
  logic [CNT_W-1:0]    count_q,  count_d;
  logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]   lane_fifo_q [MAX_TRANSACTION];
  logic [LANE_W-1:0]   lane_fifo_d [MAX_TRANSACTION];

  logic                       lite_ar_fire, nasti_ar_fire, nasti_r_fire;
  logic [LANE_W-1:0]          lane_in;
  logic [LITE_DATA_WIDTH-1:0] beat_words [RATIO];
  logic                       unused_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_TRANSACTION - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake qualifiers are held low through reset so nothing transfers while
  // the NASTI slave is being reset alongside us.
  assign nasti_r_ready = !rst && (!r_valid_q || lite_r_ready);
  assign nasti_r_fire  = nasti_r_valid && nasti_r_ready;

  assign lite_ar_ready = !rst
                      && (!ar_valid_q || nasti_ar_ready)
                      && ((count_q < CNT_W'(MAX_TRANSACTION)) || nasti_r_fire)
                      && ((count_q == '0) || (lite_ar_id == cur_id_q));
  assign lite_ar_fire  = lite_ar_valid && lite_ar_ready;
  assign nasti_ar_fire = nasti_ar_valid && nasti_ar_ready;

  assign lane_in     = (RATIO > 1) ? lite_ar_addr[WORD_LSB +: LANE_W] : '0;
  assign unused_last = nasti_r_last;

  always_comb begin
    for (int i = 0; i < RATIO; i++) begin
      beat_words[i] = nasti_r_data[i*LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
    end
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    ar_valid_d  = ar_valid_q;
    ar_id_d     = ar_id_q;
    ar_addr_d   = ar_addr_q;
    ar_size_d   = ar_size_q;
    ar_burst_d  = ar_burst_q;
    ar_prot_d   = ar_prot_q;
    ar_qos_d    = ar_qos_q;
    ar_region_d = ar_region_q;
    ar_user_d   = ar_user_q;
    r_valid_d   = r_valid_q;
    r_id_d      = r_id_q;
    r_data_d    = r_data_q;
    r_resp_d    = r_resp_q;
    r_user_d    = r_user_q;
    count_d     = count_q;
    cur_id_d    = cur_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lane_fifo_d = lane_fifo_q;

    if (lite_ar_fire) begin
      ar_valid_d  = 1'b1;
      ar_id_d     = lite_ar_id;
      ar_addr_d   = lite_ar_addr;
      ar_size_d   = 3'(WORD_LSB);
      ar_burst_d  = 2'b01;
      ar_prot_d   = lite_ar_prot;
      ar_qos_d    = lite_ar_qos;
      ar_region_d = lite_ar_region;
      ar_user_d   = lite_ar_user;
      cur_id_d    = lite_ar_id;
      lane_fifo_d[wr_ptr_q] = lane_in;
      wr_ptr_d    = ptr_inc(wr_ptr_q);
    end else if (nasti_ar_fire) begin
      ar_valid_d  = 1'b0;
    end

    // The FIFO head is read before this cycle's push lands, so a full FIFO can
    // pop and push in the same cycle.
    if (nasti_r_fire) begin
      r_valid_d = 1'b1;
      r_id_d    = nasti_r_id;
      r_data_d  = beat_words[lane_fifo_q[rd_ptr_q]];
      r_resp_d  = nasti_r_resp;
      r_user_d  = nasti_r_user;
      rd_ptr_d  = ptr_inc(rd_ptr_q);
    end else if (lite_r_ready) begin
      r_valid_d = 1'b0;
    end

    case ({lite_ar_fire, nasti_r_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ar_valid_q  <= 1'b0;
      ar_id_q     <= '0;
      ar_addr_q   <= '0;
      ar_size_q   <= '0;
      ar_burst_q  <= '0;
      ar_prot_q   <= '0;
      ar_qos_q    <= '0;
      ar_region_q <= '0;
      ar_user_q   <= '0;
      r_valid_q   <= 1'b0;
      r_id_q      <= '0;
      r_data_q    <= '0;
      r_resp_q    <= '0;
      r_user_q    <= '0;
      count_q     <= '0;
      cur_id_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      // NOTE: the lane FIFO is tiny flop storage, so it is cleared with everything else rather than left as unreset memory.
      for (int i = 0; i < MAX_TRANSACTION; i++) begin
        lane_fifo_q[i] <= '0;
      end
    end else begin
      ar_valid_q  <= ar_valid_d;
      ar_id_q     <= ar_id_d;
      ar_addr_q   <= ar_addr_d;
      ar_size_q   <= ar_size_d;
      ar_burst_q  <= ar_burst_d;
      ar_prot_q   <= ar_prot_d;
      ar_qos_q    <= ar_qos_d;
      ar_region_q <= ar_region_d;
      ar_user_q   <= ar_user_d;
      r_valid_q   <= r_valid_d;
      r_id_q      <= r_id_d;
      r_data_q    <= r_data_d;
      r_resp_q    <= r_resp_d;
      r_user_q    <= r_user_d;
      count_q     <= count_d;
      cur_id_q    <= cur_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lane_fifo_q <= lane_fifo_d;
    end
  end

  assign nasti_ar_valid  = ar_valid_q && !rst;
  assign nasti_ar_id     = ar_id_q;
  assign nasti_ar_addr   = ar_addr_q;
  assign nasti_ar_len    = 8'd0;
  assign nasti_ar_size   = ar_size_q;
  assign nasti_ar_burst  = ar_burst_q;
  assign nasti_ar_lock   = 1'b0;
  assign nasti_ar_cache  = 4'b0000;
  assign nasti_ar_prot   = ar_prot_q;
  assign nasti_ar_qos    = ar_qos_q;
  assign nasti_ar_region = ar_region_q;
  assign nasti_ar_user   = ar_user_q;

  assign lite_r_valid = r_valid_q && !rst;
  assign lite_r_id    = r_id_q;
  assign lite_r_data  = r_data_q;
  assign lite_r_resp  = r_resp_q;
  assign lite_r_user  = r_user_q;

endmodule
